// File: rtl/counter_pkg.sv
// Shared types, segment patterns and helpers
// for the BCD up/down counter.
package counter_pkg;

  typedef logic [3:0] bcd_t;

  // Active-low, bit 0 = segment a .. bit 6 = segment g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic bcd_t bcd_clamp(input bcd_t v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low
// seven-segment decode with blanking.
module bcd_to_7seg
  import counter_pkg::*;
(
  input  bcd_t       bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with prescaler,
// parallel load, wrap pulse and 7-seg outputs.
module bcd_updown_counter
  import counter_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int BLANK_LZ = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NDIG-1:0]       load_value,
  output logic [4*NDIG-1:0]       digits,
  output logic [0:NDIG-1][6:0]    segments,
  output logic                    wrap
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX =
    PW'(TICK_DIV - 1);

  logic [PW-1:0]     pcount_q, pcount_d;
  logic [4*NDIG-1:0] digits_q, digits_d;
  logic              wrap_q, wrap_d;

  logic              tick;
  logic              carry;
  logic [4*NDIG-1:0] step;
  logic [4*NDIG-1:0] clamped;

  assign tick = enable && (pcount_q == PMAX);

  // carry doubles as borrow; surviving all digits means a wrap
  always_comb begin
    step  = digits_q;
    carry = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (up) begin
          if (digits_q[4*i +: 4] == 4'd9) begin
            step[4*i +: 4] = 4'd0;
          end else begin
            step[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digits_q[4*i +: 4] == 4'd0) begin
            step[4*i +: 4] = 4'd9;
          end else begin
            step[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    clamped = '0;
    for (int i = 0; i < NDIG; i++) begin
      clamped[4*i +: 4] = bcd_clamp(load_value[4*i +: 4]);
    end
  end

  always_comb begin
    digits_d = digits_q;
    pcount_d = pcount_q;
    wrap_d   = 1'b0;
    if (load) begin
      digits_d = clamped;
      pcount_d = '0;
    end else if (tick) begin
      digits_d = step;
      wrap_d   = carry;
      pcount_d = '0;
    end else if (enable) begin
      pcount_d = pcount_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digits_q <= '0;
      pcount_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      digits_q <= digits_d;
      pcount_q <= pcount_d;
      wrap_q   <= wrap_d;
    end
  end

  assign digits = digits_q;
  assign wrap   = wrap_q;

  for (genvar g = 0; g < NDIG; g++) begin : g_seg
    logic blank;
    if (g == 0) begin : g_lsd
      assign blank = 1'b0;
    end else begin : g_hi
      assign blank = (BLANK_LZ != 0) &&
        (digits_q[4*NDIG-1:4*g] == '0);
    end
    bcd_to_7seg u_dec (
      .bcd   (digits_q[4*g +: 4]),
      .blank (blank),
      .seg   (segments[g])
    );
  end

endmodule
